des_round_controller: RTL and testbench
=======================================

DES_ROUND_CONTROLLER -- requirements
Module: des_round_controller

Interface
REQ-001 SHALL have parameter ROUNDS, default 16: number of Feistel rounds executed; legal range 1..16; values below 16 are for reduced-round test only.
REQ-002 SHALL have port wClk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port wReset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port wStart, input, 1: request to process one block; sampled only in IDLE.
REQ-005 SHALL have port wDecrypt, input, 1: 1 = decrypt key order; sampled with wStart.
REQ-006 SHALL have port wInputData, input, 64: initial-permutation output {L0[63:32], R0[31:0]}; sampled with wStart.
REQ-007 SHALL have port wFResult, input, 32: combinational f(R, K) result from the external round-function block.
REQ-008 SHALL have port rRightHalf, output, 32: current R register, driven to the round function.
REQ-009 SHALL have port rRound, output, 4: current round index 0..ROUNDS-1.
REQ-010 SHALL have port rShift, output, 2: key-schedule rotate amount (0, 1 or 2) for the current round.
REQ-011 SHALL have port rShiftRight, output, 1: 1 = key schedule rotates right (decrypt).
REQ-012 SHALL have port rKeyLoad, output, 1: one-cycle pulse telling the key schedule to load PC-1 of the key.
REQ-013 SHALL have port rBusy, output, 1: high while rounds are in progress.
REQ-014 SHALL have port rDone, output, 1: one-cycle pulse when rOutputData is valid.
REQ-015 SHALL have port rOutputData, output, 64: pre-output {R16, L16} for the final permutation; held until the next completion.

Function
REQ-016 SHALL implement FSM states IDLE and ROUND; IDLE -> ROUND when wStart=1; ROUND -> IDLE on the edge completing round ROUNDS-1; no other transitions except reset.
REQ-017 On the accepting edge (T0), SHALL load L <= wInputData[63:32] and R <= wInputData[31:0], latch wDecrypt, set rRound=0 and rBusy=1, and drive rKeyLoad=1 for the following cycle only.
REQ-018 Each ROUND edge SHALL perform L <= R, R <= L ^ wFResult, rRound <= rRound+1.
REQ-019 On the final round edge (T_ROUNDS), SHALL load rOutputData <= {L ^ wFResult, R}, i.e. the swap is undone, and set rDone=1 and rBusy=0 for exactly one cycle of rDone.
REQ-020 Latency SHALL be ROUNDS+1 cycles from the wStart sample to rDone high; with ROUNDS=16, rDone is high in the 17th cycle after T0.
REQ-021 Encrypt: rShift by rRound SHALL be 1 for rounds 0, 1, 8 and 15, else 2; rShiftRight=0.
REQ-022 Decrypt: rShift SHALL be 0 for round 0, 1 for rounds 1, 8 and 15, else 2; rShiftRight=1.
REQ-023 rShift, rShiftRight and rRound SHALL be registered, not combinational from wStart; rShift=0 outside ROUND.
REQ-024 wStart SHALL be ignored while in ROUND; wInputData and wDecrypt changes during ROUND SHALL have no effect.
REQ-025 wStart=1 in the rDone cycle (already IDLE) SHALL be accepted, allowing back-to-back blocks every ROUNDS+1 cycles.

Reset
REQ-026 wReset=1 SHALL, at the next edge, force IDLE and clear L, R, rRound, rShift, rShiftRight, rKeyLoad, rBusy, rDone and rOutputData to 0, overriding wStart.
REQ-027 Reset mid-operation SHALL abort the block with no rDone pulse; wStart in the first cycle after reset deassertion SHALL be accepted.

Configuration
REQ-028 Macro DES_DECRYPT_EN defined: wDecrypt SHALL behave per REQ-005 and REQ-022.
REQ-029 Macro DES_DECRYPT_EN undefined: wDecrypt SHALL be ignored, rShiftRight SHALL be constant 0, and all blocks SHALL use the encrypt shift table; the port list is unchanged.

Verification
REQ-030 wFResult=0, wInputData=0xAAAAAAAA_55555555, wStart pulse -> rDone in cycle 17, rOutputData=0x55555555_AAAAAAAA.
REQ-031 Encrypt run -> rShift sequence over rounds 0..15 = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; rShiftRight=0; rKeyLoad high exactly one cycle after T0.
REQ-032 Decrypt run (DES_DECRYPT_EN defined) -> rShift = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; rShiftRight=1.
REQ-033 Full system with key 0x133457799BBCDFF1 and plaintext 0x0123456789ABCDEF -> ciphertext 0x85E813540F0AB405; decrypting it returns the plaintext.
REQ-034 wStart held high continuously -> blocks complete every 17 cycles; a wStart pulse at round 5 is ignored (one rDone only).
REQ-035 wReset at round 7 -> all outputs 0 next cycle, no rDone; a new wStart afterwards yields the correct result.

Source files
------------

// File: rtl/des_round_controller.sv
// DES Feistel round sequencer: holds L/R halves, steps ROUNDS rounds against an external f(R, K),
// and drives key-schedule shift controls. Define DES_DECRYPT_EN to enable decrypt key ordering.
module des_round_controller #(
    parameter int unsigned ROUNDS = 16
) (
    input  logic        wClk,
    input  logic        wReset,
    input  logic        wStart,
    input  logic        wDecrypt,
    input  logic [63:0] wInputData,
    input  logic [31:0] wFResult,
    output logic [31:0] rRightHalf,
    output logic [3:0]  rRound,
    output logic [1:0]  rShift,
    output logic        rShiftRight,
    output logic        rKeyLoad,
    output logic        rBusy,
    output logic        rDone,
    output logic [63:0] rOutputData
);

    typedef enum logic {
        StIdle,
        StRound
    } state_e;

    localparam logic [3:0] LastRound = 4'(ROUNDS - 1);

    state_e      r_state;
    logic [31:0] r_left;
    logic        r_decrypt;

    state_e      w_state_next;
    logic [31:0] w_left_next;
    logic [31:0] w_right_next;
    logic [3:0]  w_round_next;
    logic [1:0]  w_shift_next;
    logic        w_shift_right_next;
    logic        w_key_load_next;
    logic        w_busy_next;
    logic        w_done_next;
    logic [63:0] w_out_next;
    logic        w_decrypt_next;
    logic        w_decrypt_in;
    logic [31:0] w_feistel;

`ifdef DES_DECRYPT_EN
    assign w_decrypt_in = wDecrypt;
`else
    logic w_unused_decrypt;
    assign w_unused_decrypt = wDecrypt;
    assign w_decrypt_in     = 1'b0;
`endif

    assign w_feistel = r_left ^ wFResult;

    // Decrypt rotates right and skips the rotate before round 0, since C16/D16 equal C0/D0.
    function automatic logic [1:0] shift_for(input logic [3:0] round, input logic decrypt);
        if (round == 4'd0) begin
            return decrypt ? 2'd0 : 2'd1;
        end else if (round == 4'd1 || round == 4'd8 || round == 4'd15) begin
            return 2'd1;
        end else begin
            return 2'd2;
        end
    endfunction

    always_comb begin
        w_state_next       = r_state;
        w_left_next        = r_left;
        w_right_next       = rRightHalf;
        w_round_next       = rRound;
        w_shift_next       = rShift;
        w_shift_right_next = rShiftRight;
        w_key_load_next    = 1'b0;
        w_busy_next        = rBusy;
        w_done_next        = 1'b0;
        w_out_next         = rOutputData;
        w_decrypt_next     = r_decrypt;

        unique case (r_state)
            StIdle: begin
                w_shift_next       = 2'd0;
                w_shift_right_next = 1'b0;
                if (wStart) begin
                    w_state_next       = StRound;
                    w_left_next        = wInputData[63:32];
                    w_right_next       = wInputData[31:0];
                    w_decrypt_next     = w_decrypt_in;
                    w_round_next       = 4'd0;
                    w_shift_next       = shift_for(4'd0, w_decrypt_in);
                    w_shift_right_next = w_decrypt_in;
                    w_key_load_next    = 1'b1;
                    w_busy_next        = 1'b1;
                end
            end
            StRound: begin
                w_left_next  = rRightHalf;
                w_right_next = w_feistel;
                if (rRound == LastRound) begin
                    // Final swap is undone: output is {R16, L16}.
                    w_state_next       = StIdle;
                    w_out_next         = {w_feistel, rRightHalf};
                    w_done_next        = 1'b1;
                    w_busy_next        = 1'b0;
                    w_round_next       = 4'd0;
                    w_shift_next       = 2'd0;
                    w_shift_right_next = 1'b0;
                end else begin
                    w_round_next = rRound + 4'd1;
                    w_shift_next = shift_for(rRound + 4'd1, r_decrypt);
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge wClk) begin
        if (wReset) begin
            r_state     <= StIdle;
            r_left      <= '0;
            r_decrypt   <= 1'b0;
            rRightHalf  <= '0;
            rRound      <= '0;
            rShift      <= '0;
            rShiftRight <= 1'b0;
            rKeyLoad    <= 1'b0;
            rBusy       <= 1'b0;
            rDone       <= 1'b0;
            rOutputData <= '0;
        end else begin
            r_state     <= w_state_next;
            r_left      <= w_left_next;
            r_decrypt   <= w_decrypt_next;
            rRightHalf  <= w_right_next;
            rRound      <= w_round_next;
            rShift      <= w_shift_next;
            rShiftRight <= w_shift_right_next;
            rKeyLoad    <= w_key_load_next;
            rBusy       <= w_busy_next;
            rDone       <= w_done_next;
            rOutputData <= w_out_next;
        end
    end

`ifndef SYNTHESIS
    a_done_not_busy : assert property (@(posedge wClk) disable iff (wReset) rDone |-> !rBusy);
    a_busy_state : assert property (@(posedge wClk) disable iff (wReset)
        rBusy == (r_state == StRound));
`endif

endmodule

// File: tb/tb_des_round_controller.sv
// Randomized self-checking bench for des_round_controller against a behavioural Feistel model.
module tb_des_round_controller;

    localparam int unsigned ROUNDS = 16;
    localparam int ENC_SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        wClk = 1'b0;
    logic        wReset;
    logic        wStart;
    logic        wDecrypt;
    logic [63:0] wInputData;
    logic [31:0] wFResult;
    logic [31:0] rRightHalf;
    logic [3:0]  rRound;
    logic [1:0]  rShift;
    logic        rShiftRight;
    logic        rKeyLoad;
    logic        rBusy;
    logic        rDone;
    logic [63:0] rOutputData;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] keys [16];
    bit          f_zero = 1'b0;

    des_round_controller #(.ROUNDS(ROUNDS)) dut (
        .wClk        (wClk),
        .wReset      (wReset),
        .wStart      (wStart),
        .wDecrypt    (wDecrypt),
        .wInputData  (wInputData),
        .wFResult    (wFResult),
        .rRightHalf  (rRightHalf),
        .rRound      (rRound),
        .rShift      (rShift),
        .rShiftRight (rShiftRight),
        .rKeyLoad    (rKeyLoad),
        .rBusy       (rBusy),
        .rDone       (rDone),
        .rOutputData (rOutputData)
    );

    always #5 wClk = ~wClk;

    function automatic logic [31:0] f_model(input logic [31:0] r, input logic [31:0] k);
        return {r[15:0], r[31:16]} ^ k ^ (r * 32'h9E3779B1);
    endfunction

    // Stand-in for the external round function, keyed per round.
    assign wFResult = f_zero ? 32'h0 : f_model(rRightHalf, keys[rRound]);

    function automatic logic [63:0] model_block(input logic [63:0] din);
        logic [31:0] l, r, t;
        l = din[63:32];
        r = din[31:0];
        for (int i = 0; i < int'(ROUNDS); i++) begin
            t = r;
            r = l ^ f_model(r, keys[i]);
            l = t;
        end
        return {r, l};
    endfunction

    function automatic bit eff_dec(input bit dec);
`ifdef DES_DECRYPT_EN
        return dec;
`else
        return 1'b0;
`endif
    endfunction

    // Decrypt rotation undoes encrypt rotation in reverse order, with nothing before round 0.
    function automatic int exp_shift(input int round, input bit dec);
        if (!eff_dec(dec)) return ENC_SCHED[round];
        return (round == 0) ? 0 : ENC_SCHED[16 - round];
    endfunction

    task automatic tick();
        @(posedge wClk);
        #1;
    endtask

    task automatic randomize_keys();
        for (int i = 0; i < 16; i++) keys[i] = $urandom;
    endtask

    task automatic start_block(input logic [63:0] din, input bit dec);
        wStart     = 1'b1;
        wInputData = din;
        wDecrypt   = dec;
        tick();
        wStart     = 1'b0;
        wInputData = {$urandom, $urandom};
        wDecrypt   = ~dec;
    endtask

    task automatic test_reset();
        wReset     = 1'b1;
        wStart     = 1'b1;
        wDecrypt   = 1'b1;
        wInputData = {$urandom, $urandom};
        tick();
        tick();
        n_checks++;
        if ({rRound, rShift, rShiftRight, rKeyLoad, rBusy, rDone} !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h want 000", {rRound, rShift, rShiftRight, rKeyLoad,
                     rBusy, rDone});
        end
        n_checks++;
        if (rRightHalf !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_right: got %h want 0", rRightHalf);
        end
        n_checks++;
        if (rOutputData !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_out: got %h want 0", rOutputData);
        end
        wReset = 1'b0;
        wStart = 1'b0;
        tick();
        n_checks++;
        if (rBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b want 0", rBusy);
        end
    endtask

    task automatic test_known_vector();
        int cyc;
        f_zero = 1'b1;
        start_block(64'hAAAAAAAA_55555555, 1'b0);
        cyc = 1;
        while (rDone !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc != 17) begin
            n_fail++;
            $display("FAIL kv_latency: got %0d want 17", cyc);
        end
        n_checks++;
        if (rOutputData !== 64'h55555555_AAAAAAAA) begin
            n_fail++;
            $display("FAIL kv_out: got %h want 55555555aaaaaaaa", rOutputData);
        end
        f_zero = 1'b0;
        tick();
    endtask

    task automatic test_rounds(input bit dec, input int n_blocks);
        logic [63:0] din, exp;
        for (int b = 0; b < n_blocks; b++) begin
            randomize_keys();
            din = {$urandom, $urandom};
            exp = model_block(din);
            start_block(din, dec);
            for (int cyc = 1; cyc <= int'(ROUNDS); cyc++) begin
                n_checks++;
                if (rBusy !== 1'b1 || rDone !== 1'b0) begin
                    n_fail++;
                    $display("FAIL run_flags c%0d: busy=%b done=%b want 1 0", cyc, rBusy, rDone);
                end
                n_checks++;
                if (rRound !== 4'(cyc - 1)) begin
                    n_fail++;
                    $display("FAIL round c%0d: got %0d want %0d", cyc, rRound, cyc - 1);
                end
                n_checks++;
                if (rShift !== 2'(exp_shift(cyc - 1, dec))) begin
                    n_fail++;
                    $display("FAIL shift r%0d dec=%b: got %0d want %0d", cyc - 1, dec, rShift,
                             exp_shift(cyc - 1, dec));
                end
                n_checks++;
                if (rShiftRight !== eff_dec(dec)) begin
                    n_fail++;
                    $display("FAIL shift_right: got %b want %b", rShiftRight, eff_dec(dec));
                end
                n_checks++;
                if (rKeyLoad !== (cyc == 1)) begin
                    n_fail++;
                    $display("FAIL key_load c%0d: got %b want %b", cyc, rKeyLoad, cyc == 1);
                end
                tick();
            end
            n_checks++;
            if (rDone !== 1'b1 || rBusy !== 1'b0 || rShift !== 2'd0) begin
                n_fail++;
                $display("FAIL done_flags: done=%b busy=%b shift=%0d want 1 0 0", rDone, rBusy,
                         rShift);
            end
            n_checks++;
            if (rOutputData !== exp) begin
                n_fail++;
                $display("FAIL out dec=%b: got %h want %h", dec, rOutputData, exp);
            end
            tick();
            n_checks++;
            if (rDone !== 1'b0 || rOutputData !== exp) begin
                n_fail++;
                $display("FAIL hold: done=%b out=%h want 0 %h", rDone, rOutputData, exp);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [63:0] din, exp, got;
        int n_done, done_cyc;
        randomize_keys();
        din = {$urandom, $urandom};
        exp = model_block(din);
        n_done = 0;
        done_cyc = 0;
        got = '0;
        start_block(din, 1'b0);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            wStart = (rBusy === 1'b1 && rRound == 4'd5);
            if (wStart) wInputData = ~din;
            if (rDone === 1'b1) begin
                n_done++;
                done_cyc = cyc;
                got = rOutputData;
            end
            tick();
        end
        wStart = 1'b0;
        n_checks++;
        if (n_done != 1 || done_cyc != 17) begin
            n_fail++;
            $display("FAIL ignore_start: dones=%0d at %0d want 1 at 17", n_done, done_cyc);
        end
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL ignore_out: got %h want %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b;
        randomize_keys();
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        wStart     = 1'b1;
        wDecrypt   = 1'b0;
        wInputData = a;
        tick();
        wInputData = b;
        for (int cyc = 1; cyc <= 35; cyc++) begin
            if (cyc == 18) wInputData = {$urandom, $urandom};
            if (cyc == 34) wStart = 1'b0;
            if (cyc == 17 || cyc == 34) begin
                n_checks++;
                if (rDone !== 1'b1 || rOutputData !== model_block(cyc == 17 ? a : b)) begin
                    n_fail++;
                    $display("FAIL b2b_done c%0d: done=%b out=%h want 1 %h", cyc, rDone,
                             rOutputData, model_block(cyc == 17 ? a : b));
                end
            end else begin
                n_checks++;
                if (rDone !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_spurious c%0d: done=%b want 0", cyc, rDone);
                end
            end
            if (cyc == 18) begin
                n_checks++;
                if (rBusy !== 1'b1 || rRound !== 4'd0 || rKeyLoad !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_restart: busy=%b round=%0d kl=%b want 1 0 1", rBusy,
                             rRound, rKeyLoad);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] a, b;
        int cyc;
        randomize_keys();
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        start_block(a, 1'b0);
        cyc = 0;
        while (rRound !== 4'd7 && cyc < 30) begin
            tick();
            cyc++;
        end
        wReset = 1'b1;
        tick();
        n_checks++;
        if ({rRound, rShift, rShiftRight, rKeyLoad, rBusy, rDone} !== 10'h0 ||
            rRightHalf !== 32'h0 || rOutputData !== 64'h0) begin
            n_fail++;
            $display("FAIL mid_reset: ctrl=%h right=%h out=%h want 0", {rRound, rShift,
                     rShiftRight, rKeyLoad, rBusy, rDone}, rRightHalf, rOutputData);
        end
        wReset = 1'b0;
        start_block(b, 1'b0);
        n_checks++;
        if (rBusy !== 1'b1 || rRound !== 4'd0) begin
            n_fail++;
            $display("FAIL post_reset_start: busy=%b round=%0d want 1 0", rBusy, rRound);
        end
        cyc = 1;
        while (rDone !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc != 17 || rOutputData !== model_block(b)) begin
            n_fail++;
            $display("FAIL post_reset_block: cyc=%0d out=%h want 17 %h", cyc, rOutputData,
                     model_block(b));
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) keys[i] = '0;
        wReset     = 1'b1;
        wStart     = 1'b0;
        wDecrypt   = 1'b0;
        wInputData = '0;
        test_reset();
        test_known_vector();
        test_rounds(1'b0, 6);
        test_rounds(1'b1, 6);
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
